image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 98; the number of UART bytes per image (98 x 8 = 784 pixels, 28x28).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10; the width of the pixel write address.
REQ-003 SHALL have port clk, input, 1 bit; the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port rx_rdy, input, 1 bit; byte-valid from uart_rx; level signal, so only its rising edge counts.
REQ-006 SHALL have port rx_data, input, 8 bits; received byte, valid while rx_rdy is high.
REQ-007 SHALL have port img_ack, input, 1 bit; consumer releases the loaded image.
REQ-008 SHALL have port wr_en, output, 1 bit; pixel RAM write strobe.
REQ-009 SHALL have port wr_addr, output, ADDR_WIDTH bits; pixel RAM address.
REQ-010 SHALL have port wr_data, output, 1 bit; pixel value.
REQ-011 SHALL have port img_rdy, output, 1 bit; all NUM_BYTES*8 pixels are written.
REQ-012 SHALL have port overrun, output, 1 bit; sticky dropped-byte flag (see Configuration).

Function
REQ-013 SHALL register rx_rdy once (rdy_q) and treat rx_rdy & ~rdy_q as a byte event.
REQ-014 SHALL implement FSM states IDLE, UNPACK and FULL.
REQ-015 In IDLE, a byte event SHALL latch rx_data into an 8-bit shift register, clear the bit counter and enter UNPACK on the same edge.
REQ-016 In UNPACK, SHALL assert wr_en for exactly 8 consecutive cycles.
REQ-017 In UNPACK, wr_data SHALL be the shift register LSB; pixel order is LSB first.
REQ-018 In UNPACK, wr_addr SHALL be the pixel counter; both SHALL advance by 1 per written bit.
REQ-019 The first wr_en cycle SHALL be the cycle after the edge that latched the byte.
REQ-020 After the 8th bit, SHALL return to IDLE, unless pixel counter = NUM_BYTES*8-1, then SHALL enter FULL.
REQ-021 In FULL, SHALL hold img_rdy=1 and wr_en=0, and leave the pixel counter at NUM_BYTES*8.
REQ-022 In FULL, img_ack=1 SHALL clear the pixel counter and img_rdy, and return to IDLE on the next edge.
REQ-023 A byte event during UNPACK or FULL SHALL be dropped; the counter and shift register SHALL be unchanged.
REQ-024 img_ack outside FULL SHALL be ignored.
REQ-025 wr_addr SHALL never exceed NUM_BYTES*8-1 while wr_en=1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, all counters 0, shift register 0 and rdy_q 0.
REQ-027 rst_n low SHALL immediately force wr_en, wr_addr, wr_data, img_rdy and overrun to 0.
REQ-028 Reset mid-UNPACK SHALL abandon the partial image; the next byte after release SHALL write address 0.
REQ-029 If rx_rdy is already high at reset release, it SHALL register as a byte event on the first clock.

Configuration
REQ-030 The macro LOADER_OVERRUN_EN SHALL select whether dropped-byte detection is compiled in.
REQ-031 With LOADER_OVERRUN_EN defined, any dropped byte event SHALL set overrun to 1.
REQ-032 With LOADER_OVERRUN_EN defined, overrun SHALL stay 1 until reset or the img_ack that leaves FULL.
REQ-033 With LOADER_OVERRUN_EN undefined, overrun SHALL be constant 0 and no detection logic SHALL exist.

Verification
REQ-034 Byte 0xA5 at reset state -> wr_en high 8 cycles; addr 0..7; data 1,0,1,0,0,1,0,1.
REQ-035 98 bytes 0xFF with gaps >= 10 cycles -> 784 writes, addr 0..783; img_rdy rises the cycle after addr 783.
REQ-036 Hold rx_rdy high 20 cycles with one byte -> exactly 8 writes.
REQ-037 Second rx_rdy edge 3 cycles into UNPACK -> byte ignored, address continuity kept, overrun=1 (0 without macro).
REQ-038 Byte while img_rdy=1, then img_ack -> no writes; img_rdy drops; next byte writes addr 0.
REQ-039 Reset asserted at addr 300 -> outputs 0 asynchronously; next byte after release writes addr 0.

Source files
------------

// File: rtl/image_loader_if.sv
// Image loader bus: the UART byte input, the consumer handshake and the
// pixel RAM write port, bundled for the image_loader block.
// The master modport is the loader side; the slave modport is the
// UART/consumer/RAM side.
interface image_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  rx_rdy;
   logic [7:0]            rx_data;
   logic                  img_ack;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_data;
   logic                  img_rdy;
   logic                  overrun;

   modport master (
      input  rx_rdy,
      input  rx_data,
      input  img_ack,
      output wr_en,
      output wr_addr,
      output wr_data,
      output img_rdy,
      output overrun
   );

   modport slave (
      output rx_rdy,
      output rx_data,
      output img_ack,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  img_rdy,
      input  overrun
   );
endinterface

// File: rtl/image_loader.sv
// Image loader: unpacks UART bytes into a 1-bit pixel RAM, LSB first,
// one pixel per clock.  Once NUM_BYTES*8 pixels are written it holds
// img_rdy until the consumer acknowledges with img_ack.
// Optional feature: define LOADER_OVERRUN_EN to compile in the sticky
// overrun flag for byte events dropped while busy; without it overrun
// is tied to 0.
module image_loader #(
   parameter int NUM_BYTES  = 98,
   parameter int ADDR_WIDTH = 10
) (
   input logic           clk,
   input logic           rst_n,
   image_loader_if.master bus
);

   localparam int NUM_PIXELS = NUM_BYTES * 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UNPACK = 2'd1,
      FULL   = 2'd2
   } state_t;

   state_t                state;
   logic                  rdy_q;
   logic [7:0]            shift_reg;
   logic [2:0]            bit_cnt;
   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic                  wr_en_q;
   logic                  img_rdy_q;
   logic                  byte_evt;

   // rx_rdy is a level, so only its rising edge marks a new byte
   assign byte_evt = bus.rx_rdy & ~rdy_q;

   // The write address is the pixel counter and the pixel is the shift
   // register LSB; both are registers, so the outputs are glitch free
   assign bus.wr_addr = pix_cnt;
   assign bus.wr_data = shift_reg[0];
   assign bus.wr_en   = wr_en_q;
   assign bus.img_rdy = img_rdy_q;

   // Loader FSM: latch a byte in IDLE, stream its 8 bits in UNPACK,
   // park in FULL once the whole image has been written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy_q     <= 1'b0;
         shift_reg <= 8'd0;
         bit_cnt   <= 3'd0;
         pix_cnt   <= '0;
         wr_en_q   <= 1'b0;
         img_rdy_q <= 1'b0;
      end else begin
         rdy_q <= bus.rx_rdy;
         case (state)
            IDLE: begin
               if (byte_evt) begin
                  shift_reg <= bus.rx_data;
                  bit_cnt   <= 3'd0;
                  wr_en_q   <= 1'b1;
                  state     <= UNPACK;
               end
            end
            UNPACK: begin
               shift_reg <= {1'b0, shift_reg[7:1]};
               pix_cnt   <= pix_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
                  wr_en_q <= 1'b0;
                  if (pix_cnt == LAST_PIXEL) begin
                     img_rdy_q <= 1'b1;
                     state     <= FULL;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            FULL: begin
               if (bus.img_ack) begin
                  pix_cnt   <= '0;
                  img_rdy_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LOADER_OVERRUN_EN
   logic overrun_q;

   assign bus.overrun = overrun_q;

   // Sticky flag for bytes that arrive while busy; the acknowledge that
   // releases the image clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (state == FULL && bus.img_ack) begin
         overrun_q <= 1'b0;
      end else if (byte_evt && state != IDLE) begin
         overrun_q <= 1'b1;
      end
   end
`else
   assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader.  A negedge monitor logs
// every pixel write; scenarios compare the log and the flags against
// hand-computed values.
module tb_image_loader;

   localparam int NUM_BYTES  = 98;
   localparam int ADDR_WIDTH = 10;

`ifdef LOADER_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [ADDR_WIDTH-1:0] addrQ[$];
   logic                  dataQ[$];
   int   lastWrCycle  = -1;
   int   rdyRiseCycle = -1;
   logic rdyPrev      = 1'b0;

   image_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

   image_loader #(
      .NUM_BYTES (NUM_BYTES),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle counter used to time img_rdy against the last write
   always @(posedge clk) cycle <= cycle + 1;

   // Log every write and the rising edge of img_rdy, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.wr_en) begin
         addrQ.push_back(bus.wr_addr);
         dataQ.push_back(bus.wr_data);
         if (bus.wr_addr == ADDR_WIDTH'(NUM_BYTES * 8 - 1)) lastWrCycle = cycle;
      end
      if (bus.img_rdy && !rdyPrev) rdyRiseCycle = cycle;
      rdyPrev = bus.img_rdy;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input int holdCycles,
                                input int gapCycles);
      @(negedge clk);
      bus.rx_data = data;
      bus.rx_rdy  = 1'b1;
      repeat (holdCycles) @(negedge clk);
      bus.rx_rdy = 1'b0;
      repeat (gapCycles) @(negedge clk);
   endtask

   task automatic clearLog();
      addrQ.delete();
      dataQ.delete();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] addrAt(input int idx);
      if (idx < addrQ.size()) return 32'(addrQ[idx]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [7:0] byteAt(input int idx);
      logic [7:0] b;
      b = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (idx + i < dataQ.size()) b[i] = dataQ[idx + i];
         else b[i] = 1'bx;
      end
      return b;
   endfunction

   initial begin
      logic [7:0] patA5;
      int         bad;
      int         found;

      bus.rx_rdy  = 1'b0;
      bus.rx_data = 8'd0;
      bus.img_ack = 1'b0;
      patA5       = 8'hA5;

      // Reset state
      #12;
      checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
      checkOutput("rst_wr_addr", 32'(bus.wr_addr), 0);
      checkOutput("rst_wr_data", 32'(bus.wr_data), 0);
      checkOutput("rst_img_rdy", 32'(bus.img_rdy), 0);
      checkOutput("rst_overrun", 32'(bus.overrun), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single byte 0xA5: 8 writes, addr 0..7, LSB first
      clearLog();
      applyStimulus(8'hA5, 1, 12);
      checkOutput("a5_count", 32'(addrQ.size()), 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("a5_addr%0d", i), addrAt(i), 32'(i));
         checkOutput($sformatf("a5_bit%0d", i),
                     (i < dataQ.size()) ? 32'(dataQ[i]) : 32'hFFFF_FFFF,
                     32'(patA5[i]));
      end

      // rx_rdy held high 20 cycles: one byte only
      clearLog();
      applyStimulus(8'h3C, 20, 12);
      checkOutput("hold_count", 32'(addrQ.size()), 8);
      checkOutput("hold_first", addrAt(0), 8);
      checkOutput("hold_last", addrAt(7), 15);
      checkOutput("hold_byte", 32'(byteAt(0)), 32'h3C);

      // Second rx_rdy edge three cycles into UNPACK is dropped
      clearLog();
      @(negedge clk);
      bus.rx_data = 8'h0F;
      bus.rx_rdy  = 1'b1;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      bus.rx_data = 8'hF0;
      bus.rx_rdy  = 1'b1;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("drop_count", 32'(addrQ.size()), 8);
      checkOutput("drop_first", addrAt(0), 16);
      checkOutput("drop_last", addrAt(7), 23);
      checkOutput("drop_byte", 32'(byteAt(0)), 32'h0F);
      checkOutput("drop_overrun", 32'(bus.overrun), 32'(OVR_EXP));
      applyStimulus(8'h81, 1, 12);
      checkOutput("cont_count", 32'(addrQ.size()), 16);
      checkOutput("cont_first", addrAt(8), 24);
      checkOutput("cont_byte", 32'(byteAt(8)), 32'h81);

      // Full image of 0xFF bytes
      doReset();
      clearLog();
      rdyRiseCycle = -1;
      lastWrCycle  = -1;
      checkOutput("fill_ovr_clr", 32'(bus.overrun), 0);
      for (int b = 0; b < NUM_BYTES; b++) applyStimulus(8'hFF, 1, 11);
      checkOutput("fill_count", 32'(addrQ.size()), NUM_BYTES * 8);
      bad = 0;
      for (int i = 0; i < addrQ.size(); i++) begin
         if (addrQ[i] != ADDR_WIDTH'(i) || dataQ[i] !== 1'b1) bad++;
      end
      checkOutput("fill_seq_bad", 32'(bad), 0);
      checkOutput("fill_last_seen", 32'(lastWrCycle >= 0), 1);
      checkOutput("fill_rdy_delay", 32'(rdyRiseCycle - lastWrCycle), 1);
      checkOutput("full_img_rdy", 32'(bus.img_rdy), 1);
      checkOutput("full_wr_en", 32'(bus.wr_en), 0);

      // Byte while full is dropped, then acknowledge
      clearLog();
      applyStimulus(8'h55, 1, 12);
      checkOutput("full_no_wr", 32'(addrQ.size()), 0);
      checkOutput("full_rdy_hold", 32'(bus.img_rdy), 1);
      checkOutput("full_overrun", 32'(bus.overrun), 32'(OVR_EXP));
      @(negedge clk);
      bus.img_ack = 1'b1;
      @(negedge clk);
      bus.img_ack = 1'b0;
      checkOutput("ack_rdy_drop", 32'(bus.img_rdy), 0);
      checkOutput("ack_ovr_clr", 32'(bus.overrun), 0);
      applyStimulus(8'h01, 1, 12);
      checkOutput("ack_first", addrAt(0), 0);
      checkOutput("ack_byte", 32'(byteAt(0)), 32'h01);

      // img_ack outside FULL is ignored
      @(negedge clk);
      bus.img_ack = 1'b1;
      repeat (2) @(negedge clk);
      bus.img_ack = 1'b0;
      applyStimulus(8'h80, 1, 12);
      checkOutput("ign_count", 32'(addrQ.size()), 16);
      checkOutput("ign_first", addrAt(8), 8);
      checkOutput("ign_byte", 32'(byteAt(8)), 32'h80);

      // Reset mid-unpack at address 300
      doReset();
      for (int b = 0; b < 37; b++) applyStimulus(8'h5A, 1, 10);
      @(negedge clk);
      bus.rx_data = 8'hC3;
      bus.rx_rdy  = 1'b1;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         if (bus.wr_en && bus.wr_addr == ADDR_WIDTH'(300)) found = 1;
         else @(negedge clk);
      end
      checkOutput("mid_reach300", 32'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_wr_en", 32'(bus.wr_en), 0);
      checkOutput("mid_wr_addr", 32'(bus.wr_addr), 0);
      checkOutput("mid_wr_data", 32'(bus.wr_data), 0);
      checkOutput("mid_img_rdy", 32'(bus.img_rdy), 0);
      checkOutput("mid_overrun", 32'(bus.overrun), 0);

      // rx_rdy already high at release counts as a byte on the first clock
      bus.rx_data = 8'h02;
      bus.rx_rdy  = 1'b1;
      repeat (2) @(negedge clk);
      clearLog();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      bus.rx_rdy = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("rel_count", 32'(addrQ.size()), 8);
      checkOutput("rel_first", addrAt(0), 0);
      checkOutput("rel_byte", 32'(byteAt(0)), 32'h02);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
